alu_issue_buffer: RTL and testbench

ALU_ISSUE_BUFFER -- requirements
Module: alu_issue_buffer

---
 rtl/alu_issue_buffer_pkg.sv | 16 +
 rtl/alu_issue_buffer_select.sv | 34 +++
 rtl/alu_issue_buffer.sv | 108 ++++++++++
 tb/tb_alu_issue_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_buffer_pkg.sv
// Shared types for the ALU issue buffer: the functional-unit packet and
// the default issue / ALU widths used by the buffer and its selector.
package alu_issue_buffer_pkg;

  localparam int ISSUE_W    = 2;
  localparam int NUM_FU_ALU = 2;
  localparam int TAG_W      = 8;
  localparam int DATA_W     = 16;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } FU_PACKET;

endpackage

// File: rtl/alu_issue_buffer_select.sv
// Oldest-first mapping of the head window of a queue onto the available
// functional units: the i-th available unit (counting from index 0) gets
// the i-th oldest entry, as long as that many entries are held.
module alu_issue_select
  import alu_issue_buffer_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_ALU,
  parameter int CW     = 4
) (
  input  FU_PACKET [NUM_FU-1:0] window,
  input  logic [CW-1:0]         count,
  input  logic [NUM_FU-1:0]     avail,
  output FU_PACKET [NUM_FU-1:0] fu_packet,
  output logic [CW-1:0]         k
);

  // Walk units in index order, handing out head entries until the queue runs dry.
  always_comb begin
    int rank;
    rank      = 0;
    fu_packet = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (avail[i] && (rank < int'(count))) begin
        for (int j = 0; j < NUM_FU; j++) begin
          if (j == rank) fu_packet[i] = window[j];
        end
        fu_packet[i].valid = 1'b1;
        rank++;
      end
    end
    k = CW'(rank);
  end

endmodule

// File: rtl/alu_issue_buffer.sv
// Circular issue buffer between the reservation station and the ALUs.
// Packets are compacted on entry, held in strict age order, and handed to
// available ALUs oldest-first straight from registered state.
module alu_issue_buffer
  import alu_issue_buffer_pkg::*;
#(
  parameter int N      = ISSUE_W,
  parameter int NUM_FU = NUM_FU_ALU,
  parameter int DEPTH  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  FU_PACKET [N-1:0]           rs_packet,
  input  logic [NUM_FU-1:0]          alu_avail,
  output FU_PACKET [NUM_FU-1:0]      fu_alu_packet,
  output logic [$clog2(DEPTH+1)-1:0] free_slots,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  FU_PACKET              mem [DEPTH];

  FU_PACKET [NUM_FU-1:0] window;
  logic [NUM_FU-1:0]     avail_eff;
  logic [CW-1:0]         k;
  logic [CW-1:0]         accepted;
  logic [N-1:0]          wr_en;
  logic [PW-1:0]         wr_off [N];
  logic                  drop;
  logic                  live;

  // Nothing moves in or out while reset is held or a flush is in progress.
  assign live       = reset && !squash;
  assign avail_eff  = live ? alu_avail : '0;
  assign free_slots = CW'(DEPTH) - count;

  // Present the oldest NUM_FU entries to the selector.
  always_comb begin
    for (int j = 0; j < NUM_FU; j++) begin
      window[j] = mem[head + PW'(j)];
    end
  end

  alu_issue_select #(
    .NUM_FU (NUM_FU),
    .CW     (CW)
  ) u_select (
    .window    (window),
    .count     (count),
    .avail     (avail_eff),
    .fu_packet (fu_alu_packet),
    .k         (k)
  );

  // Compact valid slots onto consecutive tail offsets, limited by registered free space.
  always_comb begin
    int acc;
    acc  = 0;
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr_en[i]  = 1'b0;
      wr_off[i] = '0;
      if (live && rs_packet[i].valid) begin
        if (acc < int'(free_slots)) begin
          wr_en[i]  = 1'b1;
          wr_off[i] = PW'(acc);
          acc++;
        end else begin
          drop = 1'b1;
        end
      end
    end
    accepted = CW'(acc);
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(k);
      tail  <= tail + PW'(accepted);
      count <= count + accepted - k;
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage; occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (wr_en[i]) mem[tail + wr_off[i]] <= rs_packet[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Bench for alu_issue_buffer: directed scenarios plus a randomized run,
// all compared against a queue-based model of the buffer.
module tb_alu_issue_buffer;
  import alu_issue_buffer_pkg::*;

  localparam int N     = 2;
  localparam int NF    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               squash = 1'b0;
  FU_PACKET [N-1:0]   rs_packet = '0;
  logic [NF-1:0]      alu_avail = '0;
  FU_PACKET [NF-1:0]  fu_alu_packet;
  logic [CW-1:0]      free_slots;
  logic               overflow;

  int passed = 0;
  int total  = 0;

  FU_PACKET mq[$];
  bit       movf = 1'b0;
  int       next_tag = 100;

  alu_issue_buffer #(.N(N), .NUM_FU(NF), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .rs_packet     (rs_packet),
    .alu_avail     (alu_avail),
    .fu_alu_packet (fu_alu_packet),
    .free_slots    (free_slots),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  function automatic FU_PACKET mk(input int t);
    FU_PACKET p;
    p.valid = 1'b1;
    p.tag   = 8'(t);
    p.data  = 16'($urandom);
    return p;
  endfunction

  // Expected packet on ALU i given the model queue and the current inputs.
  function automatic FU_PACKET exp_pkt(input int i);
    FU_PACKET p;
    int rank;
    p = '0;
    rank = 0;
    if (!reset || squash || !alu_avail[i]) return p;
    for (int j = 0; j < i; j++) if (alu_avail[j]) rank++;
    if (rank < mq.size()) p = mq[rank];
    return p;
  endfunction

  // Apply the buffer's rules to the model for the current inputs, then clock.
  task automatic advance();
    int k;
    int freec;
    k = 0;
    if (!reset) begin
      mq.delete();
      movf = 1'b0;
    end else if (squash) begin
      mq.delete();
    end else begin
      freec = DEPTH - mq.size();
      for (int i = 0; i < NF; i++) if (alu_avail[i] && k < mq.size()) k++;
      repeat (k) void'(mq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (rs_packet[i].valid) begin
          if (freec > 0) begin
            mq.push_back(rs_packet[i]);
            freec--;
          end else begin
            movf = 1'b1;
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; squash = 1'b0; rs_packet = '0; alu_avail = '0;
    advance();
    advance();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rs_packet = {mk(2), mk(1)};
    alu_avail = 2'b11;
    advance();
    #3;
    total++;
    if (fu_alu_packet[0].valid !== 1'b0 || fu_alu_packet[1].valid !== 1'b0)
      $display("FAIL reset_out valid=%b%b expected 00", fu_alu_packet[1].valid, fu_alu_packet[0].valid);
    else passed++;
    advance();
    reset = 1'b1; rs_packet = '0; alu_avail = '0;
    #3;
    total++;
    if (free_slots !== CW'(DEPTH)) $display("FAIL reset_free got %0d expected %0d", free_slots, DEPTH);
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf got %b expected 0", overflow);
    else passed++;
    advance();
  endtask

  task automatic test_basic();
    do_reset();
    rs_packet = {mk(6), mk(5)};
    alu_avail = 2'b00;
    advance();
    rs_packet = '0;
    for (int c = 0; c < 2; c++) begin
      #3;
      total++;
      if (fu_alu_packet[0].valid !== 1'b0 || fu_alu_packet[1].valid !== 1'b0)
        $display("FAIL basic_hold valid=%b%b expected 00", fu_alu_packet[1].valid, fu_alu_packet[0].valid);
      else passed++;
      total++;
      if (free_slots !== CW'(DEPTH-2)) $display("FAIL basic_free got %0d expected %0d", free_slots, DEPTH-2);
      else passed++;
      advance();
    end
    alu_avail = 2'b11;
    #3;
    total++;
    if (fu_alu_packet[0].valid !== 1'b1 || fu_alu_packet[0].tag !== 8'd5)
      $display("FAIL basic_alu0 valid=%b tag=%0d expected 1/5", fu_alu_packet[0].valid, fu_alu_packet[0].tag);
    else passed++;
    total++;
    if (fu_alu_packet[1].valid !== 1'b1 || fu_alu_packet[1].tag !== 8'd6)
      $display("FAIL basic_alu1 valid=%b tag=%0d expected 1/6", fu_alu_packet[1].valid, fu_alu_packet[1].tag);
    else passed++;
    total++;
    if (fu_alu_packet !== {exp_pkt(1), exp_pkt(0)})
      $display("FAIL basic_data got %h expected %h", fu_alu_packet, {exp_pkt(1), exp_pkt(0)});
    else passed++;
    advance();
    alu_avail = 2'b00;
    #3;
    total++;
    if (free_slots !== CW'(DEPTH)) $display("FAIL basic_drain got %0d expected %0d", free_slots, DEPTH);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    alu_avail = 2'b00;
    for (int c = 0; c < 4; c++) begin
      rs_packet = {mk(2*c+2), mk(2*c+1)};
      advance();
    end
    rs_packet = '0;
    rs_packet[0] = mk(9);
    #3;
    total++;
    if (free_slots !== '0) $display("FAIL full_free got %0d expected 0", free_slots);
    else passed++;
    advance();
    rs_packet = '0;
    #3;
    total++;
    if (overflow !== 1'b1) $display("FAIL full_ovf got %b expected 1", overflow);
    else passed++;
    total++;
    if (free_slots !== '0) $display("FAIL full_free_after got %0d expected 0", free_slots);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      alu_avail = 2'b11;
      #3;
      total++;
      if (fu_alu_packet[0].valid !== 1'b1 || fu_alu_packet[0].tag !== 8'(2*c+1) ||
          fu_alu_packet[1].valid !== 1'b1 || fu_alu_packet[1].tag !== 8'(2*c+2))
        $display("FAIL drain_order tags=%0d,%0d expected %0d,%0d",
                 fu_alu_packet[0].tag, fu_alu_packet[1].tag, 2*c+1, 2*c+2);
      else passed++;
      total++;
      if (overflow !== 1'b1) $display("FAIL drain_ovf got %b expected 1", overflow);
      else passed++;
      advance();
    end
    alu_avail = 2'b00;
    #3;
    total++;
    if (free_slots !== CW'(DEPTH)) $display("FAIL drain_free got %0d expected %0d", free_slots, DEPTH);
    else passed++;
  endtask

  task automatic test_partial_avail();
    do_reset();
    rs_packet = {mk(2), mk(1)};
    advance();
    rs_packet = '0;
    rs_packet[0] = mk(3);
    advance();
    rs_packet = '0;
    alu_avail = 2'b10;
    #3;
    total++;
    if (fu_alu_packet[0].valid !== 1'b0) $display("FAIL partial_alu0 valid=%b expected 0", fu_alu_packet[0].valid);
    else passed++;
    total++;
    if (fu_alu_packet[1].valid !== 1'b1 || fu_alu_packet[1].tag !== 8'd1)
      $display("FAIL partial_alu1 valid=%b tag=%0d expected 1/1", fu_alu_packet[1].valid, fu_alu_packet[1].tag);
    else passed++;
    advance();
    alu_avail = 2'b11;
    #3;
    total++;
    if (fu_alu_packet[0].tag !== 8'd2 || fu_alu_packet[1].tag !== 8'd3 ||
        fu_alu_packet[0].valid !== 1'b1 || fu_alu_packet[1].valid !== 1'b1)
      $display("FAIL partial_next tags=%0d,%0d expected 2,3", fu_alu_packet[0].tag, fu_alu_packet[1].tag);
    else passed++;
    advance();
    alu_avail = 2'b00;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 60; c++) begin
      rs_packet = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          rs_packet[i] = mk(next_tag);
          next_tag = (next_tag + 1) % 256;
        end
      end
      alu_avail = NF'($urandom);
      #3;
      for (int i = 0; i < NF; i++) begin
        total++;
        if (fu_alu_packet[i] !== exp_pkt(i))
          $display("FAIL wrap_out cycle %0d alu %0d got %h expected %h", c, i, fu_alu_packet[i], exp_pkt(i));
        else passed++;
      end
      total++;
      if (free_slots !== CW'(DEPTH - mq.size()))
        $display("FAIL wrap_free cycle %0d got %0d expected %0d", c, free_slots, DEPTH - mq.size());
      else passed++;
      total++;
      if (overflow !== movf) $display("FAIL wrap_ovf cycle %0d got %b expected %b", c, overflow, movf);
      else passed++;
      advance();
    end
    rs_packet = '0;
    alu_avail = '0;
  endtask

  task automatic test_squash();
    do_reset();
    alu_avail = 2'b00;
    rs_packet = {mk(11), mk(10)}; advance();
    rs_packet = {mk(13), mk(12)}; advance();
    rs_packet = '0; rs_packet[0] = mk(14); advance();
    rs_packet = {mk(21), mk(20)};
    squash = 1'b1;
    alu_avail = 2'b11;
    #3;
    total++;
    if (fu_alu_packet[0].valid !== 1'b0 || fu_alu_packet[1].valid !== 1'b0)
      $display("FAIL squash_out valid=%b%b expected 00", fu_alu_packet[1].valid, fu_alu_packet[0].valid);
    else passed++;
    advance();
    squash = 1'b0;
    rs_packet = '0;
    #3;
    total++;
    if (free_slots !== CW'(DEPTH)) $display("FAIL squash_free got %0d expected %0d", free_slots, DEPTH);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (fu_alu_packet[0].valid !== 1'b0 || fu_alu_packet[1].valid !== 1'b0)
        $display("FAIL squash_stale cycle %0d tags=%0d,%0d", c, fu_alu_packet[0].tag, fu_alu_packet[1].tag);
      else passed++;
      advance();
    end
    total++;
    if (overflow !== 1'b0) $display("FAIL squash_ovf got %b expected 0", overflow);
    else passed++;
    alu_avail = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    alu_avail = 2'b00;
    rs_packet = {mk(31), mk(30)}; advance();
    rs_packet = {mk(33), mk(32)}; advance();
    reset = 1'b0;
    squash = 1'b1;
    alu_avail = 2'b11;
    rs_packet = {mk(41), mk(40)};
    #3;
    total++;
    if (fu_alu_packet[0].valid !== 1'b0 || fu_alu_packet[1].valid !== 1'b0)
      $display("FAIL rstmid_out valid=%b%b expected 00", fu_alu_packet[1].valid, fu_alu_packet[0].valid);
    else passed++;
    advance();
    reset = 1'b1;
    squash = 1'b0;
    rs_packet = '0;
    #3;
    total++;
    if (free_slots !== CW'(DEPTH)) $display("FAIL rstmid_free got %0d expected %0d", free_slots, DEPTH);
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL rstmid_ovf got %b expected 0", overflow);
    else passed++;
    total++;
    if (fu_alu_packet[0].valid !== 1'b0 || fu_alu_packet[1].valid !== 1'b0)
      $display("FAIL rstmid_empty valid=%b%b expected 00", fu_alu_packet[1].valid, fu_alu_packet[0].valid);
    else passed++;
    advance();
    alu_avail = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_partial_avail();
    test_wrap();
    test_squash();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
